// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage: one outstanding imem request, IF/ID register,
// stall hold buffer, flush and redirect with in-flight discard. Optional: PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] next_pc_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [63:0] pc_o,
    output logic [63:0] pc_plus4_o,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef PC_ALIGN_CHECK_EN
    output logic        fetch_misalign_o,
`endif
    output logic        ifid_valid_o,
    output logic [63:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q;
    logic [63:0] pc_load;
    logic [63:0] hold_pc_q;
    logic [31:0] hold_instr_q;
    logic        misaligned;
    logic        gnt_ok;
    logic        pc_en;
    logic        hold_load;
    logic        hold_clr;
    logic        ifid_load;
    logic [63:0] ifid_load_pc;
    logic [31:0] ifid_load_instr;

`ifdef PC_ALIGN_CHECK_EN
    assign pc_load    = next_pc_i;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign fetch_misalign_o = rst_n && (state_q == S_REQ) && misaligned;
`else
    assign pc_load    = next_pc_i & ~64'h3;
    assign misaligned = 1'b0;
`endif

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign pc_plus4_o  = pc_q + 64'd4;
    assign imem_req_o  = rst_n && (state_q == S_REQ) && !misaligned;
    assign gnt_ok      = imem_req_o && imem_gnt_i;

    always_comb begin
        state_d         = state_q;
        pc_en           = 1'b0;
        hold_load       = 1'b0;
        hold_clr        = 1'b0;
        ifid_load       = 1'b0;
        ifid_load_pc    = pc_q;
        ifid_load_instr = imem_rdata_i;
        case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    pc_en   = 1'b1;
                    state_d = gnt_ok ? S_DROP : S_REQ;
                end else if (gnt_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_en   = 1'b1;
                    state_d = imem_rvalid_i ? S_REQ : S_DROP;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        hold_load = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_en     = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_en    = 1'b1;
                    hold_clr = 1'b1;
                    state_d  = S_REQ;
                end else if (!stall_i) begin
                    ifid_load       = 1'b1;
                    ifid_load_pc    = hold_pc_q;
                    ifid_load_instr = hold_instr_q;
                    pc_en           = 1'b1;
                    hold_clr        = 1'b1;
                    state_d         = S_REQ;
                end
            end
            S_DROP: begin
                // The stale response may coincide with a further redirect; consuming it
                // here keeps the unit from waiting on a response that never comes.
                if (redirect_i) pc_en = 1'b1;
                if (imem_rvalid_i) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (pc_en) pc_q <= pc_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc_q    <= 64'h0;
            hold_instr_q <= 32'h0;
        end else if (hold_load) begin
            hold_pc_q    <= pc_q;
            hold_instr_q <= imem_rdata_i;
        end else if (hold_clr) begin
            hold_pc_q    <= 64'h0;
            hold_instr_q <= 32'h0;
        end
    end

    // Flush beats a same-cycle load; the PC field is left as-is on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= 64'h0;
            ifid_instr_o <= NOP_INSTR;
        end else if (flush_i) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
        end else if (ifid_load) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= ifid_load_pc;
            ifid_instr_o <= ifid_load_instr;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed imem handshakes; a monitor checks
// every accepted request address and every IF/ID update against queued expectations.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] next_pc_i;
    logic        redirect_i, stall_i, flush_i;
    logic [63:0] pc_o, pc_plus4_o, imem_addr_o;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [63:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        fetch_misalign_o;
`endif

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc_i), .redirect_i(redirect_i),
        .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
`ifdef PC_ALIGN_CHECK_EN
        .fetch_misalign_o(fetch_misalign_o),
`endif
        .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] req_q[$];
    logic [96:0] ifid_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: accepted requests and IF/ID changes are compared in order of appearance.
    logic [96:0] ifid_prev = {1'b0, 64'h0, NOP};
    always @(negedge clk) begin
        logic [96:0] ifid_now;
        ifid_now = {ifid_valid_o, ifid_pc_o, ifid_instr_o};
        if (rst_n) begin
            if (imem_req_o && imem_gnt_i) begin
                if (req_q.size() == 0) chk("unexpected_req", {64'h0, imem_addr_o}, 128'h0);
                else chk("req_addr", {64'h0, imem_addr_o}, {64'h0, req_q.pop_front()});
            end
            if (ifid_now !== ifid_prev) begin
                if (ifid_q.size() == 0) chk("unexpected_ifid", {31'h0, ifid_now}, 128'h0);
                else chk("ifid", {31'h0, ifid_now}, {31'h0, ifid_q.pop_front()});
            end
        end
        ifid_prev = ifid_now;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        next_pc_i = 64'h0; redirect_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    endtask

    task automatic grant(input logic [63:0] addr);
        idle; imem_gnt_i = 1'b1; req_q.push_back(addr); tick;
    endtask

    initial begin
        rst_n = 1'b0;
        idle;
        repeat (3) tick;
        chk("rst_req", {127'h0, imem_req_o}, 128'h0);
        chk("rst_valid", {127'h0, ifid_valid_o}, 128'h0);
        chk("rst_ifid_pc", {64'h0, ifid_pc_o}, 128'h0);
        chk("rst_ifid_instr", {96'h0, ifid_instr_o}, {96'h0, NOP});
        chk("rst_pc", {64'h0, pc_o}, 128'h0);

        // 1: first fetch right after release, back-to-back request afterwards
        rst_n = 1'b1;
        grant(64'h0);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3860_0005; next_pc_i = 64'h4;
        ifid_q.push_back({1'b1, 64'h0, 32'h3860_0005});
        tick;
        chk("t1_pc", {64'h0, pc_o}, 128'h4);
        chk("t1_pc_plus4", {64'h0, pc_plus4_o}, 128'h8);
        chk("t1_req_b2b", {127'h0, imem_req_o}, 128'h1);

        // 2: stall for 3 cycles from rvalid, then release
        grant(64'h4);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h7C08_02A6; stall_i = 1'b1; tick;
        idle; stall_i = 1'b1;
        chk("t2_hold_req0", {127'h0, imem_req_o}, 128'h0);
        tick;
        chk("t2_hold_req1", {127'h0, imem_req_o}, 128'h0);
        tick;
        idle; next_pc_i = 64'h8;
        ifid_q.push_back({1'b1, 64'h4, 32'h7C08_02A6});
        tick;
        chk("t2_resume_req", {127'h0, imem_req_o}, 128'h1);
        chk("t2_resume_addr", {64'h0, imem_addr_o}, 128'h8);

        // 3: redirect while waiting; late response is dropped
        grant(64'h8);
        idle; redirect_i = 1'b1; next_pc_i = 64'h100; tick;
        idle;
        chk("t3_drop_noreq", {127'h0, imem_req_o}, 128'h0);
        tick;
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; tick;
        chk("t3_req_addr", {64'h0, imem_addr_o}, 128'h100);

        // 4: redirect + flush + rvalid in the same cycle
        grant(64'h100);
        idle; redirect_i = 1'b1; flush_i = 1'b1; imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hCAFE_F00D; next_pc_i = 64'h200;
        ifid_q.push_back({1'b0, 64'h4, NOP});
        tick;
        chk("t4_valid", {127'h0, ifid_valid_o}, 128'h0);
        chk("t4_addr", {64'h0, imem_addr_o}, 128'h200);
        grant(64'h200);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3880_0001; next_pc_i = 64'h204;
        ifid_q.push_back({1'b1, 64'h200, 32'h3880_0001});
        tick;

        // 5: PC wrap at the top of the address space
        idle; redirect_i = 1'b1; next_pc_i = 64'hFFFF_FFFF_FFFF_FFFC; tick;
        chk("t5_plus4_wrap", {64'h0, pc_plus4_o}, 128'h0);
        grant(64'hFFFF_FFFF_FFFF_FFFC);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h38A0_0002; next_pc_i = 64'h0;
        ifid_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h38A0_0002});
        tick;
        chk("t5_pc_wrapped", {64'h0, pc_o}, 128'h0);

        // 6: misaligned next PC
        grant(64'h0);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h38C0_0003; next_pc_i = 64'h102;
        ifid_q.push_back({1'b1, 64'h0, 32'h38C0_0003});
        tick;
`ifdef PC_ALIGN_CHECK_EN
        idle;
        chk("t6_misalign_req", {127'h0, imem_req_o}, 128'h0);
        chk("t6_misalign_flag", {127'h0, fetch_misalign_o}, 128'h1);
        tick;
        chk("t6_misalign_stays", {127'h0, imem_req_o}, 128'h0);
        redirect_i = 1'b1; next_pc_i = 64'h100; tick;
        chk("t6_realign_flag", {127'h0, fetch_misalign_o}, 128'h0);
`else
        chk("t6_aligned_addr", {64'h0, imem_addr_o}, 128'h100);
`endif
        chk("t6_req", {127'h0, imem_req_o}, 128'h1);

        // 7: stall + flush in hold keeps the held word
        grant(64'h100);
        idle; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h38E0_0004; stall_i = 1'b1; tick;
        idle; stall_i = 1'b1; flush_i = 1'b1;
        ifid_q.push_back({1'b0, 64'h0, NOP});
        tick;
        idle; next_pc_i = 64'h104;
        ifid_q.push_back({1'b1, 64'h100, 32'h38E0_0004});
        tick;
        chk("t7_pc", {64'h0, pc_o}, 128'h104);

        idle;
        repeat (3) tick;
        chk("req_q_drained", {96'h0, 32'(req_q.size())}, 128'h0);
        chk("ifid_q_drained", {96'h0, 32'(ifid_q.size())}, 128'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
